// File: rtl/dcache_miss_ctrl.sv
// D-cache miss sequencer: dirty-victim writeback, line refill,
// commit pulse, and saturating miss/writeback counters.
module dcache_miss_ctrl #(
  parameter int DW             = 32,
  parameter int AW             = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int CNTW           = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid_i,
  input  logic [AW-1:0]                     req_addr_i,
  input  logic                              hit_i,
  input  logic                              victim_dirty_i,
  input  logic [AW-1:0]                     victim_addr_i,
  input  logic [DW-1:0]                     victim_word_i,
  output logic                              stall_o,
  output logic                              mem_req_o,
  output logic                              mem_we_o,
  output logic [AW-1:0]                     mem_addr_o,
  output logic [DW-1:0]                     mem_wdata_o,
  input  logic                              mem_ack_i,
  input  logic [DW-1:0]                     mem_rdata_i,
  output logic [$clog2(WORDS_PER_LINE)-1:0] word_idx_o,
  output logic                              fill_we_o,
  output logic [DW-1:0]                     fill_data_o,
  output logic                              fill_done_o,
  output logic [CNTW-1:0]                   miss_cnt_o,
  output logic [CNTW-1:0]                   wb_cnt_o
);

  localparam int IW   = $clog2(WORDS_PER_LINE);
  localparam int OFFB = IW + 2;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    RF,
    DONE
  } state_t;

  state_t          r_state;
  state_t          w_nxt;
  logic [IW-1:0]   r_beat;
  logic [AW-1:0]   r_rf_base;
  logic [AW-1:0]   r_wb_base;
  logic [CNTW-1:0] r_miss_cnt;
  logic [CNTW-1:0] r_wb_cnt;
  logic            w_miss;
  logic            w_last;
  logic            w_beat_ack;
  logic [AW-1:0]   w_off;
  logic            w_unused;

  // Gated by rst so stall_o reads 0 while reset is held.
  assign w_miss     = rst & (r_state == IDLE) & req_valid_i & ~hit_i;
  assign w_last     = r_beat == IW'(WORDS_PER_LINE - 1);
  assign w_beat_ack = mem_ack_i & ((r_state == WB) | (r_state == RF));
  assign w_off      = AW'({r_beat, 2'b00});
  assign w_unused   = ^req_addr_i[OFFB-1:0];

  assign fill_data_o = mem_rdata_i;
  assign miss_cnt_o  = r_miss_cnt;
  assign wb_cnt_o    = r_wb_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_beat     <= '0;
      r_rf_base  <= '0;
      r_wb_base  <= '0;
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_miss) begin
        r_rf_base <= {req_addr_i[AW-1:OFFB], OFFB'(0)};
        r_wb_base <= victim_addr_i;
        r_beat    <= '0;
        if (r_miss_cnt != {CNTW{1'b1}})
          r_miss_cnt <= r_miss_cnt + CNTW'(1);
        if (victim_dirty_i && r_wb_cnt != {CNTW{1'b1}})
          r_wb_cnt <= r_wb_cnt + CNTW'(1);
      end else if (w_beat_ack) begin
        r_beat <= r_beat + IW'(1);
      end
    end
  end

  always_comb begin
    w_nxt       = r_state;
    stall_o     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    word_idx_o  = '0;
    fill_we_o   = 1'b0;
    fill_done_o = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_miss) begin
          stall_o = 1'b1;
          w_nxt   = victim_dirty_i ? WB : RF;
        end
      end
      WB: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = r_wb_base + w_off;
        mem_wdata_o = victim_word_i;
        word_idx_o  = r_beat;
        if (mem_ack_i && w_last)
          w_nxt = RF;
      end
      RF: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = r_rf_base + w_off;
        word_idx_o = r_beat;
        fill_we_o  = mem_ack_i;
        if (mem_ack_i && w_last)
          w_nxt = DONE;
      end
      DONE: begin
        stall_o     = 1'b1;
        fill_done_o = 1'b1;
        w_nxt       = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl with an expected-beat
// scoreboard queue and a simple memory/cache responder.
module tb_dcache_miss_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic [31:0] req_addr_i;
  logic        hit_i;
  logic        victim_dirty_i;
  logic [31:0] victim_addr_i;
  logic [31:0] victim_word_i;
  logic        stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic [1:0]  word_idx_o;
  logic        fill_we_o;
  logic [31:0] fill_data_o;
  logic        fill_done_o;
  logic [1:0]  miss_cnt_o;
  logic [1:0]  wb_cnt_o;

  dcache_miss_ctrl #(
    .DW(32), .AW(32), .WORDS_PER_LINE(4), .CNTW(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid_i(req_valid_i),
    .req_addr_i(req_addr_i),
    .hit_i(hit_i),
    .victim_dirty_i(victim_dirty_i),
    .victim_addr_i(victim_addr_i),
    .victim_word_i(victim_word_i),
    .stall_o(stall_o),
    .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i),
    .word_idx_o(word_idx_o),
    .fill_we_o(fill_we_o),
    .fill_data_o(fill_data_o),
    .fill_done_o(fill_done_o),
    .miss_cnt_o(miss_cnt_o),
    .wb_cnt_o(wb_cnt_o)
  );

  always #5 clk = ~clk;

  // Cache data array model: victim word tagged with its index.
  assign victim_word_i = {16'hD1C7, 14'd0, word_idx_o};

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  idx;
  } beat_t;

  beat_t q[$];
  int    ncmp = 0;
  int    nfail = 0;
  int    scnt;
  int    exp_miss = 0;
  int    exp_wb = 0;
  int    sat_tab[5] = '{1, 2, 3, 3, 3};

  function automatic logic [31:0] rd(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_miss(input logic [31:0] addr, input logic dirty,
                         input logic [31:0] vaddr, input int wt,
                         input int lb, input int lwt, input int exp_stall);
    beat_t       b;
    int          bi;
    int          w;
    logic [31:0] base;
    base = addr & ~32'hF;
    @(negedge clk);
    req_valid_i = 1'b1;
    hit_i = 1'b0;
    req_addr_i = addr;
    victim_dirty_i = dirty;
    victim_addr_i = vaddr;
    #1;
    chk("miss_stall", {31'd0, stall_o}, 1);
    chk("miss_noreq", {31'd0, mem_req_o}, 0);
    scnt = stall_o ? 1 : 0;
    if (dirty)
      for (int i = 0; i < 4; i++)
        q.push_back('{1'b1, vaddr + 32'(4 * i),
                      {16'hD1C7, 14'd0, 2'(i)}, 2'(i)});
    for (int i = 0; i < 4; i++)
      q.push_back('{1'b0, base + 32'(4 * i),
                    rd(base + 32'(4 * i)), 2'(i)});
    if (exp_miss < 3) exp_miss++;
    if (dirty && exp_wb < 3) exp_wb++;
    bi = 0;
    @(negedge clk);
    // Junk on request-side inputs while busy.
    req_valid_i = 1'b0;
    req_addr_i = 32'hFFFF_FFFC;
    victim_dirty_i = ~dirty;
    victim_addr_i = 32'h0BAD_0000;
    while (q.size() > 0) begin
      b = q.pop_front();
      w = (bi == lb) ? lwt : wt;
      #1;
      chk("req", {31'd0, mem_req_o}, 1);
      chk("we", {31'd0, mem_we_o}, {31'd0, b.we});
      chk("addr", mem_addr_o, b.addr);
      chk("idx", {30'd0, word_idx_o}, {30'd0, b.idx});
      if (b.we) chk("wdata", mem_wdata_o, b.data);
      if (stall_o) scnt++;
      for (int k = 0; k < w; k++) begin
        chk("wait_nofill", {31'd0, fill_we_o}, 0);
        @(negedge clk);
        #1;
        chk("wait_req", {31'd0, mem_req_o}, 1);
        chk("wait_addr", mem_addr_o, b.addr);
        if (stall_o) scnt++;
      end
      mem_ack_i = 1'b1;
      mem_rdata_i = rd(b.addr);
      #1;
      chk("fill_we", {31'd0, fill_we_o}, {31'd0, ~b.we});
      chk("no_done", {31'd0, fill_done_o}, 0);
      if (!b.we) chk("fill_data", fill_data_o, b.data);
      @(negedge clk);
      mem_ack_i = 1'b0;
      bi++;
    end
    #1;
    chk("done", {31'd0, fill_done_o}, 1);
    chk("done_req", {31'd0, mem_req_o}, 0);
    if (stall_o) scnt++;
    @(negedge clk);
    #1;
    chk("done_drop", {31'd0, fill_done_o}, 0);
    chk("idle_stall", {31'd0, stall_o}, 0);
    chk("stall_cycles", scnt, exp_stall);
    chk("miss_cnt", {30'd0, miss_cnt_o}, exp_miss);
    chk("wb_cnt", {30'd0, wb_cnt_o}, exp_wb);
  endtask

  initial begin
    rst = 1'b0;
    req_valid_i = 1'b0;
    req_addr_i = '0;
    hit_i = 1'b0;
    victim_dirty_i = 1'b0;
    victim_addr_i = '0;
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    #2;
    chk("rst_stall", {31'd0, stall_o}, 0);
    chk("rst_req", {31'd0, mem_req_o}, 0);
    chk("rst_we", {31'd0, mem_we_o}, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_idx", {30'd0, word_idx_o}, 0);
    chk("rst_fill", {30'd0, fill_we_o, fill_done_o}, 0);
    chk("rst_cnt", {28'd0, miss_cnt_o, wb_cnt_o}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Hit path
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_valid_i = 1'b1;
      hit_i = 1'b1;
      req_addr_i = 32'h0000_4000 + 32'(4 * i);
      #1;
      chk("hit_stall", {31'd0, stall_o}, 0);
      chk("hit_req", {31'd0, mem_req_o}, 0);
    end
    chk("hit_cnt", {30'd0, miss_cnt_o}, 0);
    req_valid_i = 1'b0;

    // Clean miss, 2-cycle ack latency
    do_miss(32'h0000_1234, 1'b0, 32'h0000_7770, 2, -1, 0, 14);
    // Dirty miss, zero-wait ack
    do_miss(32'h0000_1230, 1'b1, 32'h0000_8030, 0, -1, 0, 10);
    // Stalling memory on refill beat 2
    do_miss(32'h0000_2048, 1'b0, 32'h0000_0000, 0, 2, 20, 26);

    // Reset in the middle of a refill
    @(negedge clk);
    req_valid_i = 1'b1;
    hit_i = 1'b0;
    req_addr_i = 32'h0000_3004;
    victim_dirty_i = 1'b0;
    @(negedge clk);
    req_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("pre_rst_addr", mem_addr_o, 32'h0000_3000 + 32'(4 * i));
      mem_ack_i = 1'b1;
      mem_rdata_i = rd(mem_addr_o);
      #1;
      chk("pre_rst_fill", {31'd0, fill_we_o}, 1);
      @(negedge clk);
      mem_ack_i = 1'b0;
    end
    #1;
    chk("pre_rst_req", {31'd0, mem_req_o}, 1);
    rst = 1'b0;
    mem_ack_i = 1'b1;
    #1;
    chk("arst_req", {31'd0, mem_req_o}, 0);
    chk("arst_fill", {31'd0, fill_we_o}, 0);
    chk("arst_stall", {31'd0, stall_o}, 0);
    chk("arst_addr", mem_addr_o, 0);
    chk("arst_cnt", {28'd0, miss_cnt_o, wb_cnt_o}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("arst_nodone", {31'd0, fill_done_o}, 0);
    end
    mem_ack_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_miss = 0;
    exp_wb = 0;
    do_miss(32'h0000_3004, 1'b0, 32'h0000_0000, 0, -1, 0, 6);

    // Counter saturation at CNTW=2
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_miss = 0;
    exp_wb = 0;
    for (int i = 0; i < 5; i++) begin
      do_miss(32'h0000_5000 + 32'(16 * i), 1'b0, 32'h0, 0, -1, 0, 6);
      chk("sat", {30'd0, miss_cnt_o}, sat_tab[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
